// File: rtl/c_table_if.sv
// c_table_if: load and lookup signal bundle for the c_table C-table block.
// The master side streams counts and issues lookups; the slave side is the table.
interface c_table_if #(
    parameter int SYM_W  = 2,
    parameter int DATA_W = 8
);
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_cnt;
    logic              tbl_ready;
    logic [DATA_W-1:0] total;
    logic              ovf;
    logic              rd_en;
    logic [SYM_W-1:0]  rd_sym;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;

    modport master (
        output load_valid, load_cnt, rd_en, rd_sym,
        input  load_ready, tbl_ready, total, ovf, rd_valid, rd_data, rd_err
    );

    modport slave (
        input  load_valid, load_cnt, rd_en, rd_sym,
        output load_ready, tbl_ready, total, ovf, rd_valid, rd_data, rd_err
    );
endinterface

// File: rtl/c_table.sv
// c_table: programmable FM-index C-table. Per-symbol occurrence counts are
// streamed in symbol order, prefix sums are built on the fly, and registered
// lookups of C[sym] are served once the table is complete.
// Optional feature macro: CTABLE_SENTINEL_EN -- when defined, the running sum
// starts at 1 to account for the FM-index terminator, offsetting every C value
// and the total by +1.
module c_table #(
    parameter int SYM_W   = 2,
    parameter int SYM_NUM = 4,
    parameter int DATA_W  = 8
) (
    input logic     clk,
    input logic     rst_n,
    input logic     clr,
    c_table_if.slave bus
);
    localparam int IDX_W = $clog2(SYM_NUM + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM_NUM - 1);
`ifdef CTABLE_SENTINEL_EN
    localparam logic [DATA_W-1:0] BASE = DATA_W'(1);
`else
    localparam logic [DATA_W-1:0] BASE = '0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] c_reg [SYM_NUM];
    logic              ovf_q;
    logic              load_ready_q;
    logic              tbl_ready_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_err_q;

    logic              xfer;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] lookup;
    logic              sym_ok;

    assign xfer = bus.load_valid && load_ready_q;
    assign sum  = {1'b0, acc} + {1'b0, bus.load_cnt};

    // Read mux: select C[rd_sym] and flag whether the symbol is in the alphabet.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        lookup = '0;
        sym_ok = 1'b0;
        for (int i = 0; i < SYM_NUM; i++) begin
            if (bus.rd_sym == SYM_W'(i)) begin
                lookup = c_reg[i];
                sym_ok = 1'b1;
            end
        end
    end

    // Load FSM: accumulate counts into prefix sums; clr restarts loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking everywhere in clocked logic so all state
            // updates see the pre-edge values.
            state        <= IDLE;
            acc          <= BASE;
            idx          <= '0;
            ovf_q        <= 1'b0;
            load_ready_q <= 1'b1;
            tbl_ready_q  <= 1'b0;
            // NOTE: the table is small flop storage, so it is reset to zero
            // rather than left undefined like a RAM would be.
            for (int i = 0; i < SYM_NUM; i++) c_reg[i] <= '0;
        end else if (clr) begin
            // Table contents are kept; they stay unreadable until DONE again.
            state        <= IDLE;
            acc          <= BASE;
            idx          <= '0;
            ovf_q        <= 1'b0;
            load_ready_q <= 1'b1;
            tbl_ready_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (xfer) begin
                        for (int i = 0; i < SYM_NUM; i++) begin
                            if (idx == IDX_W'(i)) c_reg[i] <= acc;
                        end
                        acc <= sum[DATA_W-1:0];
                        if (sum[DATA_W]) ovf_q <= 1'b1;
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state        <= DONE;
                            load_ready_q <= 1'b0;
                            tbl_ready_q  <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    // Hold the table until clr or reset.
                end
                default: begin
                    state        <= IDLE;
                    load_ready_q <= 1'b1;
                    tbl_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    // Lookup path: one-cycle registered read; data/err hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                if (!sym_ok || state != DONE) begin
                    rd_data_q <= '0;
                    rd_err_q  <= 1'b1;
                end else begin
                    rd_data_q <= lookup;
                    rd_err_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.tbl_ready  = tbl_ready_q;
    assign bus.total      = acc;
    assign bus.ovf        = ovf_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_err     = rd_err_q;
endmodule

// File: tb/tb_c_table.sv
// tb_c_table: directed self-checking bench for c_table. A 4-symbol instance
// covers load, lookup, overflow, backpressure, clear and async reset; a
// 3-symbol instance covers out-of-alphabet lookups. Expected values follow
// the CTABLE_SENTINEL_EN setting of the build.
module tb_c_table;
`ifdef CTABLE_SENTINEL_EN
    localparam logic [7:0] B = 8'd1;
`else
    localparam logic [7:0] B = 8'd0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic clr3 = 1'b0;
    int   checks = 0;
    int   failures = 0;

    c_table_if #(.SYM_W(2), .DATA_W(8)) bus ();
    c_table_if #(.SYM_W(2), .DATA_W(8)) bus3 ();

    c_table #(.SYM_W(2), .SYM_NUM(4), .DATA_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus)
    );
    c_table #(.SYM_W(2), .SYM_NUM(3), .DATA_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .clr(clr3), .bus(bus3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_valid = 1'b0; bus.load_cnt = '0; bus.rd_en = 1'b0; bus.rd_sym = '0;
        bus3.load_valid = 1'b0; bus3.load_cnt = '0; bus3.rd_en = 1'b0; bus3.rd_sym = '0;
        clr = 1'b0; clr3 = 1'b0;
    endtask

    task automatic clear_table();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic load4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        bus.load_valid = 1'b1;
        bus.load_cnt = a; step();
        bus.load_cnt = b; step();
        bus.load_cnt = c; step();
        bus.load_cnt = d; step();
        bus.load_valid = 1'b0;
        bus.load_cnt = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready got %b want 1", bus.load_ready); end
        checks++; if (bus.tbl_ready !== 1'b0) begin failures++; $display("FAIL reset_tbl_ready got %b want 0", bus.tbl_ready); end
        checks++; if (bus.total !== B) begin failures++; $display("FAIL reset_total got %0d want %0d", bus.total, B); end
        checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
        checks++; if ({bus.rd_valid, bus.rd_err, bus.rd_data} !== 10'd0) begin failures++; $display("FAIL reset_rd got v=%b e=%b d=%0d want 0/0/0", bus.rd_valid, bus.rd_err, bus.rd_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_read();
        logic [7:0] exp_c [4];
        exp_c[0] = B; exp_c[1] = B + 8'd3; exp_c[2] = B + 8'd8; exp_c[3] = B + 8'd10;
        clear_table();
        bus.load_valid = 1'b1;
        bus.load_cnt = 8'd3; step();
        bus.load_cnt = 8'd5; step();
        bus.load_cnt = 8'd2; step();
        checks++; if (bus.tbl_ready !== 1'b0) begin failures++; $display("FAIL load_ready_early got %b want 0", bus.tbl_ready); end
        bus.load_cnt = 8'd4; step();
        bus.load_valid = 1'b0;
        checks++; if (bus.tbl_ready !== 1'b1) begin failures++; $display("FAIL load_tbl_ready got %b want 1", bus.tbl_ready); end
        checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL load_done_ready got %b want 0", bus.load_ready); end
        checks++; if (bus.total !== B + 8'd14) begin failures++; $display("FAIL load_total got %0d want %0d", bus.total, B + 8'd14); end
        checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL load_ovf got %b want 0", bus.ovf); end
        for (int i = 0; i < 4; i++) begin
            bus.rd_en = 1'b1;
            bus.rd_sym = 2'(i);
            step();
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b0 || bus.rd_data !== exp_c[i]) begin
                failures++; $display("FAIL read_sym%0d got v=%b e=%b d=%0d want 1/0/%0d", i, bus.rd_valid, bus.rd_err, bus.rd_data, exp_c[i]);
            end
        end
        bus.rd_en = 1'b0;
        step();
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== exp_c[3]) begin
            failures++; $display("FAIL read_hold got v=%b d=%0d want 0/%0d", bus.rd_valid, bus.rd_data, exp_c[3]);
        end
    endtask

    task automatic test_lookup_during_load();
        clear_table();
        bus.load_valid = 1'b1;
        bus.load_cnt = 8'd3; step();
        bus.load_cnt = 8'd5; step();
        bus.load_valid = 1'b0;
        bus.rd_en = 1'b1; bus.rd_sym = 2'd1;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b1 || bus.rd_data !== 8'd0) begin
            failures++; $display("FAIL read_in_load got v=%b e=%b d=%0d want 1/1/0", bus.rd_valid, bus.rd_err, bus.rd_data);
        end
        checks++; if (bus.load_ready !== 1'b1 || bus.tbl_ready !== 1'b0) begin
            failures++; $display("FAIL mid_load_flags got lr=%b tr=%b want 1/0", bus.load_ready, bus.tbl_ready);
        end
        bus.load_valid = 1'b1;
        bus.load_cnt = 8'd2; step();
        bus.load_cnt = 8'd4; bus.rd_en = 1'b1; bus.rd_sym = 2'd0;
        step();
        bus.load_valid = 1'b0; bus.rd_en = 1'b0;
        checks++; if (bus.rd_err !== 1'b1 || bus.rd_data !== 8'd0 || bus.tbl_ready !== 1'b1) begin
            failures++; $display("FAIL read_final_xfer got e=%b d=%0d tr=%b want 1/0/1", bus.rd_err, bus.rd_data, bus.tbl_ready);
        end
        bus.rd_en = 1'b1; bus.rd_sym = 2'd2;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_err !== 1'b0 || bus.rd_data !== B + 8'd8) begin
            failures++; $display("FAIL read_after_done got e=%b d=%0d want 0/%0d", bus.rd_err, bus.rd_data, B + 8'd8);
        end
    endtask

    task automatic test_overflow();
        clear_table();
        load4(8'd200, 8'd100, 8'd0, 8'd0);
        checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got %b want 1", bus.ovf); end
        checks++; if (bus.total !== B + 8'd44) begin failures++; $display("FAIL ovf_total got %0d want %0d", bus.total, B + 8'd44); end
        checks++; if (bus.tbl_ready !== 1'b1) begin failures++; $display("FAIL ovf_tbl_ready got %b want 1", bus.tbl_ready); end
        bus.rd_en = 1'b1; bus.rd_sym = 2'd1;
        step();
        checks++; if (bus.rd_data !== B + 8'd200 || bus.rd_err !== 1'b0) begin failures++; $display("FAIL ovf_c1 got d=%0d e=%b want %0d/0", bus.rd_data, bus.rd_err, B + 8'd200); end
        bus.rd_sym = 2'd2;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_data !== B + 8'd44 || bus.rd_err !== 1'b0) begin failures++; $display("FAIL ovf_c2 got d=%0d e=%b want %0d/0", bus.rd_data, bus.rd_err, B + 8'd44); end
    endtask

    // Runs after test_overflow: table is DONE with ovf set.
    task automatic test_backpressure_clear();
        bus.load_valid = 1'b1; bus.load_cnt = 8'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL bp_ready%0d got %b want 0", i, bus.load_ready); end
        end
        checks++; if (bus.total !== B + 8'd44) begin failures++; $display("FAIL bp_total got %0d want %0d", bus.total, B + 8'd44); end
        clr = 1'b1; bus.load_cnt = 8'd9; bus.rd_en = 1'b1; bus.rd_sym = 2'd2;
        step();
        clr = 1'b0; bus.load_valid = 1'b0; bus.load_cnt = '0; bus.rd_en = 1'b0;
        checks++; if (bus.rd_err !== 1'b0 || bus.rd_data !== B + 8'd44) begin failures++; $display("FAIL clr_read_pre got e=%b d=%0d want 0/%0d", bus.rd_err, bus.rd_data, B + 8'd44); end
        checks++; if (bus.tbl_ready !== 1'b0 || bus.ovf !== 1'b0 || bus.load_ready !== 1'b1) begin
            failures++; $display("FAIL clr_flags got tr=%b ovf=%b lr=%b want 0/0/1", bus.tbl_ready, bus.ovf, bus.load_ready);
        end
        checks++; if (bus.total !== B) begin failures++; $display("FAIL clr_total got %0d want %0d", bus.total, B); end
        load4(8'd1, 8'd1, 8'd1, 8'd1);
        checks++; if (bus.total !== B + 8'd4) begin failures++; $display("FAIL reload_total got %0d want %0d", bus.total, B + 8'd4); end
        for (int i = 0; i < 4; i++) begin
            bus.rd_en = 1'b1; bus.rd_sym = 2'(i);
            step();
            checks++; if (bus.rd_data !== B + 8'(i) || bus.rd_err !== 1'b0) begin
                failures++; $display("FAIL reload_c%0d got d=%0d e=%b want %0d/0", i, bus.rd_data, bus.rd_err, B + 8'(i));
            end
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_range();
        clr3 = 1'b1; step(); clr3 = 1'b0;
        bus3.load_valid = 1'b1;
        bus3.load_cnt = 8'd3; step();
        bus3.load_cnt = 8'd5; step();
        bus3.load_cnt = 8'd2; step();
        bus3.load_valid = 1'b0;
        checks++; if (bus3.tbl_ready !== 1'b1 || bus3.total !== B + 8'd10) begin
            failures++; $display("FAIL sym3_done got tr=%b total=%0d want 1/%0d", bus3.tbl_ready, bus3.total, B + 8'd10);
        end
        bus3.rd_en = 1'b1; bus3.rd_sym = 2'd3;
        step();
        checks++; if (bus3.rd_valid !== 1'b1 || bus3.rd_err !== 1'b1 || bus3.rd_data !== 8'd0) begin
            failures++; $display("FAIL sym_out_of_range got v=%b e=%b d=%0d want 1/1/0", bus3.rd_valid, bus3.rd_err, bus3.rd_data);
        end
        bus3.rd_sym = 2'd2;
        step();
        bus3.rd_en = 1'b0;
        checks++; if (bus3.rd_err !== 1'b0 || bus3.rd_data !== B + 8'd8) begin
            failures++; $display("FAIL sym_last_in_range got e=%b d=%0d want 0/%0d", bus3.rd_err, bus3.rd_data, B + 8'd8);
        end
    endtask

    task automatic test_async_reset();
        clear_table();
        bus.load_valid = 1'b1;
        bus.load_cnt = 8'd3; step();
        bus.load_cnt = 8'd5; bus.rd_en = 1'b1; bus.rd_sym = 2'd0;
        step();
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b1) begin
            failures++; $display("FAIL pre_reset_read got v=%b e=%b want 1/1", bus.rd_valid, bus.rd_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_err !== 1'b0 || bus.rd_data !== 8'd0) begin
            failures++; $display("FAIL async_rd got v=%b e=%b d=%0d want 0/0/0", bus.rd_valid, bus.rd_err, bus.rd_data);
        end
        checks++; if (bus.load_ready !== 1'b1 || bus.tbl_ready !== 1'b0 || bus.ovf !== 1'b0 || bus.total !== B) begin
            failures++; $display("FAIL async_state got lr=%b tr=%b ovf=%b total=%0d want 1/0/0/%0d", bus.load_ready, bus.tbl_ready, bus.ovf, bus.total, B);
        end
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        load4(8'd2, 8'd2, 8'd2, 8'd2);
        checks++; if (bus.tbl_ready !== 1'b1 || bus.total !== B + 8'd8) begin
            failures++; $display("FAIL post_reset_load got tr=%b total=%0d want 1/%0d", bus.tbl_ready, bus.total, B + 8'd8);
        end
        bus.rd_en = 1'b1; bus.rd_sym = 2'd3;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_err !== 1'b0 || bus.rd_data !== B + 8'd6) begin
            failures++; $display("FAIL post_reset_c3 got e=%b d=%0d want 0/%0d", bus.rd_err, bus.rd_data, B + 8'd6);
        end
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_lookup_during_load();
        test_overflow();
        test_backpressure_clear();
        test_range();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
